// File: rtl/sdram_read_checker_if.sv
// Bus bundle between the SDRAM read-path stimulus and the read-data scoreboard.
// The master side pushes expected words and read data; the slave side reports status.
interface sdram_read_checker_if #(
  parameter int DataWidth = 16,
  parameter int Depth     = 16
);
  localparam int PW = $clog2(Depth) + 1;

  logic                 exp_push;
  logic [DataWidth-1:0] exp_data;
  logic                 rd_valid;
  logic [DataWidth-1:0] rd_data;
  logic                 full;
  logic [PW-1:0]        pending;
  logic                 ok;
  logic [2:0]           err_code;
  logic [DataWidth-1:0] err_expected;
  logic [DataWidth-1:0] err_got;
  logic [31:0]          checked;

  modport master (
    output exp_push, exp_data, rd_valid, rd_data,
    input  full, pending, ok, err_code, err_expected, err_got, checked
  );

  modport slave (
    input  exp_push, exp_data, rd_valid, rd_data,
    output full, pending, ok, err_code, err_expected, err_got, checked
  );
endinterface

// File: rtl/sdram_read_checker.sv
// Read-data scoreboard for SDRAM board tests: queues expected words per read command,
// compares each returned word in order and latches the first error until reset.
module sdram_read_checker #(
  parameter int DataWidth     = 16,
  parameter int Depth         = 16,
  parameter int AllowInverted = 1,
  parameter int TimeoutCycles = 4096
) (
  input logic                 clk,
  input logic                 rst,
  sdram_read_checker_if.slave bus
);

  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;
  localparam int TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  localparam logic [PW-1:0] DEPTH_P   = PW'(Depth);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TimeoutCycles);

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_MISMATCH   = 3'd1;
  localparam logic [2:0] ERR_UNEXPECTED = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd4;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_FAIL = 1'b1;

  // Case-equality so any X/Z bit in the returned word counts as a miss.
  function automatic logic word_match(input logic [DataWidth-1:0] got,
                                      input logic [DataWidth-1:0] exp_word);
    logic direct;
    logic inverted;
    direct   = (got === exp_word);
    inverted = (got === ~exp_word);
    if (AllowInverted != 0) begin
      word_match = direct || inverted;
    end else begin
      word_match = direct;
    end
  endfunction

  logic [DataWidth-1:0] mem_r [Depth];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [PW-1:0]        pending_r;
  logic                 full_r;
  logic [0:0]           state_r;
  logic [2:0]           err_code_r;
  logic [DataWidth-1:0] err_expected_r;
  logic [DataWidth-1:0] err_got_r;
  logic [31:0]          checked_r;
  logic [TW-1:0]        tmo_cnt_r;

  logic [DataWidth-1:0] head_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 match_s;
  logic [PW-1:0]        pending_next_s;
  logic [TW-1:0]        tmo_next_s;
  logic [2:0]           err_s;
  logic                 update_s;
  logic                 mem_we_s;

  // Per-cycle pop/push decisions, timeout step and prioritised error detection.
  always_comb begin
    head_s         = mem_r[rd_ptr_r];
    pop_s          = bus.rd_valid && (pending_r != {PW{1'b0}});
    push_s         = bus.exp_push && ((pending_r != DEPTH_P) || pop_s);
    match_s        = word_match(bus.rd_data, head_s);
    pending_next_s = pending_r + PW'(push_s) - PW'(pop_s);
    tmo_next_s     = {TW{1'b0}};
    err_s          = ERR_NONE;

    if (TimeoutCycles == 0) begin
      tmo_next_s = {TW{1'b0}};
    end else if (pop_s || (pending_r == {PW{1'b0}})) begin
      tmo_next_s = {TW{1'b0}};
    end else begin
      tmo_next_s = tmo_cnt_r + TW'(1'b1);
    end

    if (pop_s && !match_s) begin
      err_s = ERR_MISMATCH;
    end else if (bus.rd_valid && (pending_r == {PW{1'b0}})) begin
      err_s = ERR_UNEXPECTED;
    end else if (bus.exp_push && (pending_r == DEPTH_P) && !pop_s) begin
      err_s = ERR_OVERFLOW;
    end else if ((TimeoutCycles != 0) && (tmo_next_s == TMO_LIMIT)) begin
      err_s = ERR_TIMEOUT;
    end else begin
      err_s = ERR_NONE;
    end

    // An error cycle freezes the queue: nothing pushed or popped on that edge.
    update_s = (state_r == ST_RUN) && (err_s == ERR_NONE);
    mem_we_s = update_s && push_s;
  end

  // Expected-word storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_ptr_r] <= bus.exp_data;
    end
  end

  // Queue bookkeeping, pass counter and sticky error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r       <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      pending_r      <= {PW{1'b0}};
      full_r         <= 1'b0;
      state_r        <= ST_RUN;
      err_code_r     <= ERR_NONE;
      err_expected_r <= {DataWidth{1'b0}};
      err_got_r      <= {DataWidth{1'b0}};
      checked_r      <= 32'd0;
      tmo_cnt_r      <= {TW{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (err_s != ERR_NONE) begin
            state_r    <= ST_FAIL;
            err_code_r <= err_s;
            case (err_s)
              ERR_MISMATCH: begin
                err_expected_r <= head_s;
                err_got_r      <= bus.rd_data;
              end
              ERR_UNEXPECTED: begin
                err_got_r <= bus.rd_data;
              end
              default: begin
                err_expected_r <= err_expected_r;
                err_got_r      <= err_got_r;
              end
            endcase
          end else begin
            pending_r <= pending_next_s;
            full_r    <= (pending_next_s == DEPTH_P);
            tmo_cnt_r <= tmo_next_s;
            if (push_s) begin
              wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end else begin
              wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
              rd_ptr_r  <= rd_ptr_r + AW'(1'b1);
              checked_r <= checked_r + 32'd1;
            end else begin
              rd_ptr_r  <= rd_ptr_r;
              checked_r <= checked_r;
            end
          end
        end
        ST_FAIL: begin
          state_r <= ST_FAIL;
        end
        default: begin
          state_r <= ST_FAIL;
        end
      endcase
    end
  end

  assign bus.full         = full_r;
  assign bus.pending      = pending_r;
  assign bus.ok           = (state_r == ST_RUN);
  assign bus.err_code     = err_code_r;
  assign bus.err_expected = err_expected_r;
  assign bus.err_got      = err_got_r;
  assign bus.checked      = checked_r;

endmodule
